tlc_phase_scheduler: RTL and testbench
======================================

Name: tlc_phase_scheduler

Overview:
- Demand-driven phase sequencer for a two-road intersection: main road, side road and a pedestrian crossing.
- Main green rests until a side-road vehicle or pedestrian demand is latched.
- Emergency requests pre-empt the current phase onto a held main-green phase.
- Phase timing is counted in ticks of an external timebase enable; lights are decoded from the registered phase for the intersection signal drivers.

Parameters:
- CW, 4, tick counter width; every duration parameter must fit in CW bits.
- MIN_GREEN, 7, minimum main-green ticks before demand is served (>=1).
- SIDE_GREEN, 5, side-green ticks (>=1).
- YELLOW, 2, yellow ticks for either road (>=1).
- ALL_RED, 1, all-red clearance ticks (>=1).
- WALK, 4, pedestrian walk ticks (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  timebase enable, one clk wide; phase timers advance only on tick.
- side_req  in  1  side-road vehicle sensor, level, synchronous.
- ped_req  in  1  pedestrian button, synchronous; any high cycle latches demand.
- emg_req  in  1  emergency pre-empt, level, synchronous.
- phase  out  3  current phase code.
- light_main  out  3  main-road lamp: 001 green, 010 yellow, 100 red.
- light_side  out  3  side-road lamp, same encoding.
- walk  out  1  pedestrian walk lamp.
- phase_start  out  1  one-cycle pulse in the first cycle of each new phase.
- side_pend  out  1  latched side-road demand.
- ped_pend  out  1  latched pedestrian demand.

Behaviour:
- Phase codes:
  - 0 MAIN_G: main 001, side 100.
  - 1 MAIN_Y: main 010, side 100.
  - 2 RED_A: both 100.
  - 3 SIDE_G: main 100, side 001.
  - 4 SIDE_Y: main 100, side 010.
  - 5 RED_B: both 100.
  - 6 WALK: both 100, walk=1.
  - 7 EMG: main 001, side 100.
- walk=1 only in WALK. Lamps are pure decode of the registered phase; no combinational path from inputs to outputs.
- Reset (async): phase=5 (RED_B), counter 0, both lamps 100, walk 0, phase_start 0, side_pend 0, ped_pend 0. The first phase after reset is MAIN_G after ALL_RED ticks.
- Counter: cleared on every phase change. Otherwise increments on tick and saturates at all-ones.
- Timed phase with duration D: exits on the tick where counter==D-1, so it lasts exactly D ticks. The new phase is visible the next clk.
- Transitions:
  - MAIN_G: exits to MAIN_Y on a tick with counter>=MIN_GREEN-1 and (side_pend|ped_pend). Otherwise it holds indefinitely.
  - MAIN_Y(YELLOW) -> RED_A.
  - RED_A(ALL_RED) -> SIDE_G if side_pend, else WALK.
  - SIDE_G(SIDE_GREEN) -> SIDE_Y.
  - SIDE_Y(YELLOW) -> RED_B.
  - WALK(WALK) -> RED_B.
  - RED_B(ALL_RED) -> WALK if ped_pend, else MAIN_G.
- Pending latches:
  - side_pend sets on any cycle with side_req=1 and clears on entry to SIDE_G.
  - ped_pend sets on ped_req=1 and clears on entry to WALK.
  - Set and clear in the same cycle: set wins.
- Emergency (emg_req=1, evaluated every clk, independent of tick):
  - MAIN_G -> EMG immediately.
  - SIDE_G -> SIDE_Y immediately, counter 0.
  - WALK -> RED_B immediately, counter 0.
  - Yellows run to completion.
  - RED_A/RED_B on expiry -> EMG instead of the normal target.
  - EMG holds while emg_req=1. On the first cycle with emg_req=0 it moves to MAIN_G with counter 0; the minimum green restarts.
- Emergency overrides demand; pending latches keep accumulating throughout.
- phase_start: registered, high for exactly one clk when the phase register changes, including the post-reset RED_B->MAIN_G change. Not asserted by reset itself.
- Illegal states are unreachable; the default recovers to RED_B with counter 0.
- Reset mid-phase returns to the reset values immediately, regardless of tick or pending state.

Test Plan:
- Reset, tick every 4 clk, no requests -> RED_B for 1 tick, then MAIN_G held for 50 ticks; one phase_start pulse total.
- side_req pulse at tick 2 of MAIN_G -> MAIN_G lasts 7 ticks, then MAIN_Y 2, RED_A 1, SIDE_G 5, SIDE_Y 2, RED_B 1, MAIN_G; side_pend clears on SIDE_G entry.
- ped_req only, after 20 MAIN_G ticks -> next tick goes MAIN_Y; RED_A goes to WALK (walk=1 for 4 ticks); RED_B; MAIN_G.
- side_req and ped_req both latched -> sequence MAIN_Y, RED_A, SIDE_G, SIDE_Y, RED_B, WALK, RED_B, MAIN_G; ped_req during WALK re-latches ped_pend=1.
- emg_req asserted at SIDE_G counter 2 -> next clk SIDE_Y, counter 0; after 2 ticks RED_B; after 1 tick EMG (main 001). emg_req drops -> MAIN_G, and side_req is then served only after 7 ticks.
- rst asserted mid-WALK between ticks -> outputs immediately phase 5, lamps 100/100, walk 0, both pend 0.

Source files
------------

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven traffic phase sequencer: main road, side road, pedestrian
// crossing, with emergency pre-emption onto a held main-green phase.
// Phase timers advance on the external tick enable; lamps decode the
// registered phase so there is no input-to-output combinational path.
module tlc_phase_scheduler #(
    parameter int CW         = 4,
    parameter int MIN_GREEN  = 7,
    parameter int SIDE_GREEN = 5,
    parameter int YELLOW     = 2,
    parameter int ALL_RED    = 1,
    parameter int WALK       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emg_req,
    output logic [2:0] phase,
    output logic [2:0] light_main,
    output logic [2:0] light_side,
    output logic       walk,
    output logic       phase_start,
    output logic       side_pend,
    output logic       ped_pend
);

    typedef enum logic [2:0] {
        P_MAIN_G = 3'd0,
        P_MAIN_Y = 3'd1,
        P_RED_A  = 3'd2,
        P_SIDE_G = 3'd3,
        P_SIDE_Y = 3'd4,
        P_RED_B  = 3'd5,
        P_WALK   = 3'd6,
        P_EMG    = 3'd7
    } phase_t;

    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_RED = 3'b100;

    // Last counter value of each timed phase (exit happens on the tick seen there)
    localparam logic [CW-1:0] MG_LAST = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] SG_LAST = CW'(SIDE_GREEN - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_LAST = CW'(ALL_RED - 1);
    localparam logic [CW-1:0] WK_LAST = CW'(WALK - 1);

    phase_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic          chg;
    logic          ent_side, ent_walk;

    // Next-phase selection; emergency checks are per clk, timers per tick
    always_comb begin
        nxt = cur;
        case (cur)
            P_MAIN_G: begin
                if (emg_req)
                    nxt = P_EMG;
                else if (tick && cnt >= MG_LAST && (side_pend || ped_pend))
                    nxt = P_MAIN_Y;
            end
            P_MAIN_Y: if (tick && cnt == Y_LAST) nxt = P_RED_A;
            P_RED_A: begin
                if (tick && cnt == AR_LAST)
                    nxt = emg_req ? P_EMG : (side_pend ? P_SIDE_G : P_WALK);
            end
            P_SIDE_G: if (emg_req || (tick && cnt == SG_LAST)) nxt = P_SIDE_Y;
            P_SIDE_Y: if (tick && cnt == Y_LAST) nxt = P_RED_B;
            P_RED_B: begin
                if (tick && cnt == AR_LAST)
                    nxt = emg_req ? P_EMG : (ped_pend ? P_WALK : P_MAIN_G);
            end
            P_WALK:   if (emg_req || (tick && cnt == WK_LAST)) nxt = P_RED_B;
            P_EMG:    if (!emg_req) nxt = P_MAIN_G;
            default:  nxt = P_RED_B;
        endcase
    end

    assign chg      = (nxt != cur);
    assign ent_side = chg && (nxt == P_SIDE_G);
    assign ent_walk = chg && (nxt == P_WALK);

    // Phase register plus the one-cycle start pulse that follows every change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= P_RED_B;
            phase_start <= 1'b0;
        end else begin
            cur         <= nxt;
            phase_start <= chg;
        end
    end

    // Tick counter: cleared on phase change, otherwise saturating count of ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (chg)
            cnt <= '0;
        else if (tick && cnt != '1)
            cnt <= cnt + CW'(1);
    end

    // Demand latches; a request in the same cycle as the clearing entry wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else begin
            side_pend <= side_req || (side_pend && !ent_side);
            ped_pend  <= ped_req  || (ped_pend  && !ent_walk);
        end
    end

    assign phase = cur;

    // Lamp decode from the registered phase only
    always_comb begin
        light_main = L_RED;
        light_side = L_RED;
        walk       = 1'b0;
        case (cur)
            P_MAIN_G: light_main = L_GRN;
            P_MAIN_Y: light_main = L_YEL;
            P_SIDE_G: light_side = L_GRN;
            P_SIDE_Y: light_side = L_YEL;
            P_WALK:   walk       = 1'b1;
            P_EMG:    light_main = L_GRN;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: a phase-table model tracks elapsed ticks
// per phase and is compared every cycle; directed steps pin literal phases.
module tb_tlc_phase_scheduler;

    localparam int MIN_GREEN  = 7;
    localparam int SIDE_GREEN = 5;
    localparam int YELLOW     = 2;
    localparam int ALL_RED    = 1;
    localparam int WALK       = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, side_req = 1'b0, ped_req = 1'b0, emg_req = 1'b0;
    logic [2:0] phase, light_main, light_side;
    logic       walk, phase_start, side_pend, ped_pend;

    int checks = 0;
    int errors = 0;
    int ps_cnt;

    tlc_phase_scheduler #(
        .CW(4), .MIN_GREEN(MIN_GREEN), .SIDE_GREEN(SIDE_GREEN),
        .YELLOW(YELLOW), .ALL_RED(ALL_RED), .WALK(WALK)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .side_req(side_req),
        .ped_req(ped_req), .emg_req(emg_req), .phase(phase),
        .light_main(light_main), .light_side(light_side), .walk(walk),
        .phase_start(phase_start), .side_pend(side_pend), .ped_pend(ped_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: phase table + elapsed ticks ----------------
    int m_ph, m_el;
    bit m_sp, m_pp, m_ps;

    function automatic int dur(input int p);
        case (p)
            0: return MIN_GREEN;
            1, 4: return YELLOW;
            2, 5: return ALL_RED;
            3: return SIDE_GREEN;
            6: return WALK;
            default: return 1 << 30;
        endcase
    endfunction

    function automatic int nxt_ph(input int p, input int el, input bit sp, input bit pp,
                                  input bit tk, input bit emg);
        bit done;
        done = tk && (el + 1 >= dur(p));
        case (p)
            0: return emg ? 7 : ((done && (sp || pp)) ? 1 : 0);
            1: return done ? 2 : 1;
            2: return done ? (emg ? 7 : (sp ? 3 : 6)) : 2;
            3: return (emg || done) ? 4 : 3;
            4: return done ? 5 : 4;
            5: return done ? (emg ? 7 : (pp ? 6 : 0)) : 5;
            6: return (emg || done) ? 5 : 6;
            default: return emg ? 7 : 0;
        endcase
    endfunction

    function automatic logic [6:0] lamps(input int p);
        case (p)
            0, 7: return {3'b001, 3'b100, 1'b0};
            1:    return {3'b010, 3'b100, 1'b0};
            3:    return {3'b100, 3'b001, 1'b0};
            4:    return {3'b100, 3'b010, 1'b0};
            6:    return {3'b100, 3'b100, 1'b1};
            default: return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    // Model advances on the same edges as the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 5; m_el <= 0; m_sp <= 1'b0; m_pp <= 1'b0; m_ps <= 1'b0;
        end else begin
            m_ph <= nxt_ph(m_ph, m_el, m_sp, m_pp, tick, emg_req);
            m_el <= (nxt_ph(m_ph, m_el, m_sp, m_pp, tick, emg_req) != m_ph) ? 0 : m_el + int'(tick);
            m_ps <= (nxt_ph(m_ph, m_el, m_sp, m_pp, tick, emg_req) != m_ph);
            m_sp <= side_req || (m_sp && nxt_ph(m_ph, m_el, m_sp, m_pp, tick, emg_req) != 3) ||
                    (m_sp && m_ph == 3);
            m_pp <= ped_req || (m_pp && nxt_ph(m_ph, m_el, m_sp, m_pp, tick, emg_req) != 6) ||
                    (m_pp && m_ph == 6);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("phase", int'(phase), m_ph);
            chk("lamps", int'({light_main, light_side, walk}), int'(lamps(m_ph)));
            chk("phase_start", int'(phase_start), int'(m_ps));
            chk("side_pend", int'(side_pend), int'(m_sp));
            chk("ped_pend", int'(ped_pend), int'(m_pp));
        end
    end

    // Count DUT phase_start pulses since the last reset
    always @(negedge clk) begin
        if (rst) ps_cnt <= 0;
        else if (phase_start) ps_cnt <= ps_cnt + 1;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic tks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0); cyc(0); cyc(0); cyc(1);
        end
    endtask

    task automatic pulse(input bit s, input bit p);
        side_req = s; ped_req = p;
        cyc(0);
        side_req = 1'b0; ped_req = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        // reset state
        chk("rst_phase", int'(phase), 5);
        chk("rst_lamps", int'({light_main, light_side}), 6'b100100);
        chk("rst_walk_ps", int'({walk, phase_start}), 0);
        chk("rst_pend", int'({side_pend, ped_pend}), 0);

        // idle: RED_B for one tick, then MAIN_G rests
        tks(1);
        chk("first_main_g", int'(phase), 0);
        chk("first_ps", int'(phase_start), 1);
        tks(50);
        chk("idle_main_g", int'(phase), 0);
        chk("idle_ps_count", ps_cnt, 1);

        // side demand at tick 2 of a fresh MAIN_G
        do_reset();
        tks(1); tks(2);
        pulse(1, 0);
        chk("side_latched", int'(side_pend), 1);
        tks(4); chk("sd_still_g", int'(phase), 0);
        tks(1); chk("sd_main_y", int'(phase), 1);
        tks(2); chk("sd_red_a", int'(phase), 2);
        tks(1); chk("sd_side_g", int'(phase), 3);
        chk("sd_pend_clr", int'(side_pend), 0);
        tks(5); chk("sd_side_y", int'(phase), 4);
        tks(2); chk("sd_red_b", int'(phase), 5);
        tks(1); chk("sd_main_g", int'(phase), 0);

        // pedestrian only after a long green
        tks(20);
        pulse(0, 1);
        tks(1); chk("pd_main_y", int'(phase), 1);
        tks(2); tks(1);
        chk("pd_walk", int'({phase, walk}), {3'd6, 1'b1});
        tks(4); chk("pd_red_b", int'(phase), 5);
        tks(1); chk("pd_main_g", int'(phase), 0);

        // both demands; ped re-latched during WALK
        pulse(1, 1);
        tks(7); chk("bt_main_y", int'(phase), 1);
        tks(2); tks(1); chk("bt_side_g", int'(phase), 3);
        tks(5); tks(2); tks(1); chk("bt_walk", int'(phase), 6);
        chk("bt_ped_clr", int'(ped_pend), 0);
        pulse(0, 1);
        chk("bt_ped_relatch", int'(ped_pend), 1);
        tks(4); tks(1); chk("bt_walk2", int'(phase), 6);
        tks(4); tks(1); chk("bt_main_g", int'(phase), 0);

        // emergency during SIDE_G at counter 2
        pulse(1, 0);
        tks(7); tks(2); tks(1); tks(2);
        chk("em_side_g", int'(phase), 3);
        emg_req = 1'b1;
        cyc(0); chk("em_side_y", int'(phase), 4);
        tks(1); chk("em_y_runs", int'(phase), 4);
        tks(1); chk("em_red_b", int'(phase), 5);
        tks(1); chk("em_emg", int'({phase, light_main}), {3'd7, 3'b001});
        tks(3); chk("em_hold", int'(phase), 7);
        emg_req = 1'b0;
        cyc(0); chk("em_exit", int'(phase), 0);
        pulse(1, 0);
        tks(6); chk("em_min_green", int'(phase), 0);
        tks(1); chk("em_served", int'(phase), 1);
        tks(2); tks(1); tks(5); tks(2); tks(1);
        chk("em_back_g", int'(phase), 0);

        // emergency straight from MAIN_G
        emg_req = 1'b1;
        cyc(0); chk("mg_emg", int'(phase), 7);
        emg_req = 1'b0;
        cyc(0); chk("mg_emg_exit", int'(phase), 0);

        // reset mid-WALK between ticks
        pulse(0, 1);
        tks(7); tks(2); tks(1);
        chk("rw_walk", int'(phase), 6);
        pulse(1, 1);
        cyc(0);
        rst = 1'b1;
        #1;
        chk("rw_phase", int'(phase), 5);
        chk("rw_lamps", int'({light_main, light_side, walk}), 7'b1001000);
        chk("rw_pend", int'({side_pend, ped_pend, phase_start}), 0);
        @(posedge clk); #1 rst = 1'b0;
        tks(1); chk("rw_main_g", int'(phase), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
